reg4_piso: RTL and testbench
============================

# reg4_piso

Parallel-in, serial-out transmit register. It is the counterpart to the team's 4-bit parallel D-register. It accepts a WIDTH-bit word through a valid/ready load handshake and sends it one bit per accepted serial handshake. It raises frame and completion markers so a downstream serial-to-parallel receiver or line driver can re-frame the word.

## Interface
- WIDTH, default 4: word width in bits; legal range 2..16.
- LSB_FIRST, default 1: 1 sends D[0] first; 0 sends D[WIDTH-1] first.

Ports:
- sys_clk  in  1  single clock; all state changes on its rising edge.
- sys_rst  in  1  synchronous reset, active-high.
- D  in  WIDTH  parallel word to transmit.
- load_valid  in  1  D is valid this cycle.
- load_ready  out  1  block can accept a word this cycle.
- sout  out  1  current serial bit.
- sout_valid  out  1  sout holds a valid bit.
- sout_ready  in  1  consumer accepts sout this cycle.
- frame_start  out  1  high while sout is the first bit of a word.
- done  out  1  one-cycle pulse after the last bit of a word is accepted.
- busy  out  1  a word is in flight (state SHIFT).

## Operation
- Internal state: a WIDTH-bit shift register shreg, a bit counter cnt of width clog2(WIDTH), and an FSM with states IDLE and SHIFT.
- Load handshake: a load completes on an edge where load_valid & load_ready.
- Bit handshake: a bit is transferred on an edge where sout_valid & sout_ready.
- IDLE:
  - load_ready=1, sout_valid=0, busy=0.
  - On a load: shreg<=D, cnt<=0, go to SHIFT.
- SHIFT:
  - sout_valid=1, busy=1.
  - sout = shreg[0] when LSB_FIRST=1, else shreg[WIDTH-1].
  - frame_start = (cnt==0).
- On a bit transfer that is not the last bit (cnt<WIDTH-1):
  - shreg shifts toward the output end (right when LSB_FIRST=1, left otherwise), zero-filling.
  - cnt increments.
- On the last-bit transfer (cnt==WIDTH-1):
  - done<=1 for the next cycle.
  - If load_valid is high on the same edge: back-to-back load, so shreg<=D, cnt<=0, and the FSM stays in SHIFT.
  - Otherwise: go to IDLE.
- load_ready = (state==IDLE) | (state==SHIFT & cnt==WIDTH-1 & sout_ready). It is combinational, and forced 0 while sys_rst=1.
- With sout_ready=0, sout, frame_start and cnt hold indefinitely.
- load_valid during SHIFT before the last-bit transfer is ignored. D is not sampled, and the word in flight is never corrupted.
- D is sampled only on the load edge. Changes to D afterwards have no effect.
- sout in IDLE is 0.

## Timing
- Reset: while sys_rst=1 at an edge, the next state is IDLE, shreg=0, cnt=0, done=0. sys_rst overrides any simultaneous handshake.
- Output values after reset: sout=0, sout_valid=0, frame_start=0, busy=0, done=0, load_ready=1 (load_ready is 0 during reset itself).
- Latency: a load at edge k puts the first bit on sout in cycle k+1, with frame_start=1.
- With sout_ready tied to 1, bit i appears in cycle k+1+i. done is high in cycle k+1+WIDTH only.
- Back-to-back loads with sout_ready=1 give continuous output: one bit per cycle, no idle gap. done of word n and frame_start of word n+1 are high in the same cycle.
- Reset mid-word aborts the word: no done pulse, and the next cycle is IDLE.
- Throughput: at most one word per WIDTH cycles.
- Output timing:
  - sout, sout_valid, frame_start, busy and done are derived from registered state only, with no combinational path from inputs.
  - load_ready is the only output that depends combinationally on an input (sout_ready).

## Test plan
- Reset: sys_rst=1 for 2 cycles with load_valid=1 and D=4'hF. Required: all outputs 0 and no load accepted. After release, load_ready=1 and sout_valid=0.
- Single word, LSB_FIRST=1, D=4'b1011, sout_ready=1: load at edge 0. Required: sout = 1,1,0,1 in cycles 1–4; frame_start only in cycle 1; done only in cycle 5; IDLE in cycle 5.
- Backpressure: same word, sout_ready=0 in cycles 2–4. Required: sout=1 and cnt=1 held through cycles 2–4; remaining bits resume from cycle 5; done one cycle after the fourth transfer.
- Back-to-back: 4'hA then 4'h5, the second presented on the last-bit edge of the first. Required: sout = 0,1,0,1,1,0,1,0 contiguous; done and frame_start coincide in cycle 5.
- Ignored load: load_valid=1 with D=4'h3 in cycle 2 of a 4'hC transfer. Required: sequence 0,0,1,1 unchanged and load_ready=0 in cycle 2.
- MSB_FIRST (LSB_FIRST=0), WIDTH=8, D=8'h96: required sout = 1,0,0,1,0,1,1,0. Separately, assert sys_rst in cycle 3 of a word: required no done pulse, IDLE next cycle, and a fresh load then transmits correctly.

Source files
------------

// File: rtl/reg4_piso_if.sv
// Handshake bundle for the parallel-in/serial-out transmit register.
// The slave modport is the register's view; master is the word source and bit sink.
interface reg4_piso_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] D;
  logic             load_valid;
  logic             load_ready;
  logic             sout;
  logic             sout_valid;
  logic             sout_ready;
  logic             frame_start;
  logic             done;
  logic             busy;

  modport master (
    output D, load_valid, sout_ready,
    input  load_ready, sout, sout_valid, frame_start, done, busy
  );

  modport slave (
    input  D, load_valid, sout_ready,
    output load_ready, sout, sout_valid, frame_start, done, busy
  );
endinterface

// File: rtl/reg4_piso.sv
// Parallel-in, serial-out transmit register with valid/ready load and bit handshakes.
// state | meaning:  IDLE | waiting for a word;  SHIFT | word in flight, cnt = bit index on sout
module reg4_piso #(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input logic         sys_clk,
  input logic         sys_rst,
  reg4_piso_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             done_q;
  logic             last_xfer;

  assign last_xfer = (state == SHIFT) && (cnt == LAST) && bus.sout_ready;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state  <= IDLE;
      shreg  <= '0;
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.load_valid) begin
            shreg <= bus.D;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (bus.sout_ready) begin
            if (cnt == LAST) begin
              done_q <= 1'b1;
              // back-to-back: next word enters on the last-bit edge with no gap
              if (bus.load_valid) begin
                shreg <= bus.D;
                cnt   <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              if (LSB_FIRST) shreg <= shreg >> 1;
              else           shreg <= shreg << 1;
              cnt <= cnt + CW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // everything except load_ready decodes registered state only
  assign bus.sout        = (state == SHIFT) &&
                           (LSB_FIRST ? shreg[0] : shreg[WIDTH-1]);
  assign bus.sout_valid  = (state == SHIFT);
  assign bus.busy        = (state == SHIFT);
  assign bus.frame_start = (state == SHIFT) && (cnt == '0);
  assign bus.done        = done_q;
  assign bus.load_ready  = !sys_rst && ((state == IDLE) || last_xfer);
endmodule

// File: tb/tb_reg4_piso.sv
// Directed bench: an LSB-first 4-bit instance and an MSB-first 8-bit instance.
module tb_reg4_piso;
  logic sys_clk;
  logic sys_rst;
  int   vectors;
  int   miscompares;

  reg4_piso_if #(.WIDTH(4)) ba ();
  reg4_piso_if #(.WIDTH(8)) bb ();

  reg4_piso #(.WIDTH(4), .LSB_FIRST(1'b1)) dut_a (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (ba)
  );

  reg4_piso #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_b (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bb)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] exp_bits;
    vectors     = 0;
    miscompares = 0;
    sys_rst       = 1'b1;
    ba.D          = 4'hF;
    ba.load_valid = 1'b1;
    ba.sout_ready = 1'b1;
    bb.D          = 8'h00;
    bb.load_valid = 1'b0;
    bb.sout_ready = 1'b1;

    // reset held two cycles with a load pending
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst_sout",       ba.sout,        1'b0);
      chk("rst_sout_valid", ba.sout_valid,  1'b0);
      chk("rst_busy",       ba.busy,        1'b0);
      chk("rst_done",       ba.done,        1'b0);
      chk("rst_frame",      ba.frame_start, 1'b0);
      chk("rst_load_ready", ba.load_ready,  1'b0);
    end
    sys_rst       = 1'b0;
    ba.load_valid = 1'b0;
    #1;
    chk("post_rst_load_ready", ba.load_ready, 1'b1);
    chk("post_rst_sout_valid", ba.sout_valid, 1'b0);

    // single word 1011, LSB first: 1,1,0,1
    ba.D = 4'b1011; ba.load_valid = 1'b1;
    tick();
    ba.load_valid = 1'b0; ba.D = 4'h0;
    exp_bits = 8'b0000_1011;
    for (int i = 0; i < 4; i++) begin
      chk("single_sout",  ba.sout,        exp_bits[i]);
      chk("single_frame", ba.frame_start, (i == 0));
      chk("single_done",  ba.done,        1'b0);
      chk("single_busy",  ba.busy,        1'b1);
      tick();
    end
    chk("single_done_pulse", ba.done,       1'b1);
    chk("single_idle_busy",  ba.busy,       1'b0);
    chk("single_idle_valid", ba.sout_valid, 1'b0);
    chk("single_idle_sout",  ba.sout,       1'b0);
    chk("single_idle_ready", ba.load_ready, 1'b1);
    tick();
    chk("single_done_clear", ba.done, 1'b0);

    // backpressure: sout_ready low in cycles 2..4
    ba.D = 4'b1011; ba.load_valid = 1'b1;
    tick();
    ba.load_valid = 1'b0;
    chk("bp_c1_sout",  ba.sout,        1'b1);
    chk("bp_c1_frame", ba.frame_start, 1'b1);
    tick();
    ba.sout_ready = 1'b0;
    #1;
    chk("bp_c2_load_ready", ba.load_ready, 1'b0);
    for (int c = 2; c <= 4; c++) begin
      chk("bp_hold_sout",  ba.sout,        1'b1);
      chk("bp_hold_frame", ba.frame_start, 1'b0);
      chk("bp_hold_valid", ba.sout_valid,  1'b1);
      chk("bp_hold_done",  ba.done,        1'b0);
      tick();
    end
    ba.sout_ready = 1'b1;
    chk("bp_c5_sout", ba.sout, 1'b1);
    tick();
    chk("bp_c6_sout", ba.sout, 1'b0);
    tick();
    chk("bp_c7_sout", ba.sout, 1'b1);
    chk("bp_c7_done", ba.done, 1'b0);
    tick();
    chk("bp_c8_done", ba.done, 1'b1);
    chk("bp_c8_busy", ba.busy, 1'b0);
    tick();
    chk("bp_c9_done", ba.done, 1'b0);

    // back-to-back A then 5: 0,1,0,1,1,0,1,0
    ba.D = 4'hA; ba.load_valid = 1'b1;
    tick();
    ba.load_valid = 1'b0;
    exp_bits = 8'b0000_1010;
    for (int i = 0; i < 4; i++) begin
      chk("b2b_w0_sout", ba.sout, exp_bits[i]);
      if (i == 3) begin
        ba.D = 4'h5; ba.load_valid = 1'b1;
        #1;
        chk("b2b_load_ready", ba.load_ready, 1'b1);
      end
      tick();
    end
    ba.load_valid = 1'b0;
    chk("b2b_done",  ba.done,        1'b1);
    chk("b2b_frame", ba.frame_start, 1'b1);
    chk("b2b_busy",  ba.busy,        1'b1);
    exp_bits = 8'b0000_0101;
    for (int i = 0; i < 4; i++) begin
      chk("b2b_w1_sout",  ba.sout,        exp_bits[i]);
      chk("b2b_w1_valid", ba.sout_valid,  1'b1);
      if (i > 0) chk("b2b_w1_done", ba.done, 1'b0);
      tick();
    end
    chk("b2b_w1_done_pulse", ba.done, 1'b1);
    chk("b2b_w1_idle",       ba.busy, 1'b0);
    tick();

    // ignored load mid-word: C keeps sending 0,0,1,1
    ba.D = 4'hC; ba.load_valid = 1'b1;
    tick();
    ba.load_valid = 1'b0;
    chk("ign_c1_sout", ba.sout, 1'b0);
    tick();
    ba.D = 4'h3; ba.load_valid = 1'b1;
    #1;
    chk("ign_c2_load_ready", ba.load_ready, 1'b0);
    chk("ign_c2_sout",       ba.sout,       1'b0);
    tick();
    ba.load_valid = 1'b0;
    chk("ign_c3_sout",  ba.sout,        1'b1);
    chk("ign_c3_frame", ba.frame_start, 1'b0);
    tick();
    chk("ign_c4_sout", ba.sout, 1'b1);
    tick();
    chk("ign_c5_done", ba.done, 1'b1);
    chk("ign_c5_busy", ba.busy, 1'b0);
    tick();
    chk("ign_c6_done", ba.done, 1'b0);
    chk("ign_c6_busy", ba.busy, 1'b0);

    // MSB first, WIDTH=8, 0x96: 1,0,0,1,0,1,1,0
    bb.D = 8'h96; bb.load_valid = 1'b1;
    tick();
    bb.load_valid = 1'b0;
    exp_bits = 8'b0110_1001;
    for (int i = 0; i < 8; i++) begin
      chk("msb_sout",  bb.sout,        exp_bits[i]);
      chk("msb_frame", bb.frame_start, (i == 0));
      chk("msb_done",  bb.done,        1'b0);
      tick();
    end
    chk("msb_done_pulse", bb.done, 1'b1);
    chk("msb_idle_busy",  bb.busy, 1'b0);
    tick();

    // reset in cycle 3 of a word aborts it without done
    bb.D = 8'hF0; bb.load_valid = 1'b1;
    tick();
    bb.load_valid = 1'b0;
    chk("abort_c1_sout", bb.sout, 1'b1);
    tick();
    chk("abort_c2_sout", bb.sout, 1'b1);
    tick();
    sys_rst = 1'b1;
    #1;
    chk("abort_rst_load_ready", bb.load_ready, 1'b0);
    tick();
    chk("abort_busy",  bb.busy,       1'b0);
    chk("abort_valid", bb.sout_valid, 1'b0);
    chk("abort_done",  bb.done,       1'b0);
    chk("abort_sout",  bb.sout,       1'b0);
    sys_rst = 1'b0;
    #1;
    chk("abort_load_ready", bb.load_ready, 1'b1);
    tick();
    chk("abort_no_done", bb.done, 1'b0);

    // fresh word 0x3C after the abort: 0,0,1,1,1,1,0,0
    bb.D = 8'h3C; bb.load_valid = 1'b1;
    tick();
    bb.load_valid = 1'b0;
    exp_bits = 8'b0011_1100;
    for (int i = 0; i < 8; i++) begin
      chk("fresh_sout",  bb.sout,        exp_bits[i]);
      chk("fresh_frame", bb.frame_start, (i == 0));
      tick();
    end
    chk("fresh_done", bb.done, 1'b1);
    chk("fresh_idle", bb.busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
